rx_interface: RTL and testbench

- Receive-side companion of the UART-to-ALU bridge.
- Pops bytes from the UART receiver FIFO and assembles a 3-byte command frame: operand A, operand B, opcode.
- Drives the registered ALU inputs (a, b, op), then issues a one-cycle start to the transmit interface once it is not busy.
- Sits between the rx FIFO and the ALU/tx_interface pair.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/rx_timeout_cnt.sv | 42 ++++
 rtl/rx_interface.sv | 140 ++++++++++++++
 tb/tb_rx_interface.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the UART-to-ALU bridge.
//   DBIT_DEFAULT / OPW_DEFAULT : default operand and opcode widths
//   OP_ADD .. OP_SRL           : opcode values understood by the ALU
//   rx_state_e                 : receive-side frame assembly states
//   is_legal_opcode()          : legality check for a raw opcode byte
package alu_pkg;

  localparam int unsigned DBIT_DEFAULT = 8;
  localparam int unsigned OPW_DEFAULT  = 6;

  localparam logic [OPW_DEFAULT-1:0] OP_ADD = 6'h20;
  localparam logic [OPW_DEFAULT-1:0] OP_SUB = 6'h22;
  localparam logic [OPW_DEFAULT-1:0] OP_AND = 6'h24;
  localparam logic [OPW_DEFAULT-1:0] OP_OR  = 6'h25;
  localparam logic [OPW_DEFAULT-1:0] OP_XOR = 6'h26;
  localparam logic [OPW_DEFAULT-1:0] OP_NOR = 6'h27;
  localparam logic [OPW_DEFAULT-1:0] OP_SRA = 6'h03;
  localparam logic [OPW_DEFAULT-1:0] OP_SRL = 6'h02;

  typedef enum logic [1:0] {
    StGetA,
    StGetB,
    StGetOp,
    StIssue
  } rx_state_e;

  // A legal opcode byte has its two top bits clear and names a known operation.
  function automatic logic is_legal_opcode(input logic [7:0] op_byte);
    logic ok;
    ok = 1'b0;
    if (op_byte[7:6] == 2'b00) begin
      case (op_byte[5:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Idle-cycle counter with synchronous clear and terminal-count flag.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : force count to zero (wins over en_i)
//   en_i   : advance count; wraps to zero on the cycle tc_o is high
//   tc_o   : count equals Limit-1 (never asserted when Limit is 0)
module rx_timeout_cnt #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'((Limit == 0) ? 0 : Limit - 1);
  localparam logic Enabled = (Limit != 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = Enabled && (cnt_q == TcVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !Enabled) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_interface.sv
// Receive-side frame assembler: pops operand A, operand B and opcode bytes from
// the rx FIFO, loads the registered ALU inputs and pulses start toward tx_interface.
//   clk, reset (async, active-low)
//   rx_empty, r_data : first-word-fall-through FIFO head; rd pops it
//   tx_busy          : start is withheld while high
//   a, b, op         : registered ALU inputs, updated only by a complete frame
//   start            : one-cycle pulse, a/b/op valid
//   frame_err        : one-cycle pulse, partial or illegal frame dropped
// Optional: define OPCODE_CHECK_EN to reject opcode bytes outside the legal set.
module rx_interface
  import alu_pkg::*;
#(
  parameter int unsigned DBIT           = DBIT_DEFAULT,
  parameter int unsigned OPW            = OPW_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  input  logic            tx_busy,
  output logic            rd,
  output logic [DBIT-1:0] a,
  output logic [DBIT-1:0] b,
  output logic [OPW-1:0]  op,
  output logic            start,
  output logic            frame_err
);

  rx_state_e       state_q, state_d;
  // High for the first ISSUE cycle, while a/b/op are copied from staging.
  logic            load_q, load_d;
  logic [DBIT-1:0] a_stg_q, b_stg_q, a_q, b_q;
  logic [OPW-1:0]  op_stg_q, op_q;
  logic            start_q, start_d;
  logic            frame_err_q, frame_err_d;
  logic            op_ok, in_frame, to_clr, to_en, to_tc, to_hit;

`ifdef OPCODE_CHECK_EN
  assign op_ok = is_legal_opcode(r_data[7:0]);
`else
  assign op_ok = 1'b1;
`endif

  // Idle timeout only runs while a frame is partially assembled.
  assign in_frame = (state_q == StGetB) || (state_q == StGetOp);
  assign to_clr   = rd || !in_frame;
  assign to_en    = in_frame && rx_empty;
  assign to_hit   = to_en && to_tc;

  rx_timeout_cnt #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (to_clr),
    .en_i  (to_en),
    .tc_o  (to_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StGetA;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    unique case (state_q)
      StGetA: begin
        if (rd) state_d = StGetB;
      end
      StGetB: begin
        if (rd)          state_d = StGetOp;
        else if (to_hit) state_d = StGetA;
      end
      StGetOp: begin
        if (rd) begin
          if (op_ok) begin
            state_d = StIssue;
            load_d  = 1'b1;
          end else begin
            state_d = StGetA;
          end
        end else if (to_hit) begin
          state_d = StGetA;
        end
      end
      StIssue: begin
        if (!load_q && !tx_busy) state_d = StGetA;
      end
      default: state_d = StGetA;
    endcase
  end

  // Outputs: rd is combinational, the pulses are registered below.
  always_comb begin
    rd          = !rx_empty && (state_q != StIssue);
    start_d     = (state_q == StIssue) && !load_q && !tx_busy;
    frame_err_d = to_hit || (rd && (state_q == StGetOp) && !op_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_stg_q     <= '0;
      b_stg_q     <= '0;
      op_stg_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rd && (state_q == StGetA))  a_stg_q  <= r_data;
      if (rd && (state_q == StGetB))  b_stg_q  <= r_data;
      if (rd && (state_q == StGetOp)) op_stg_q <= r_data[OPW-1:0];
      if ((state_q == StIssue) && load_q) begin
        a_q  <= a_stg_q;
        b_q  <= b_stg_q;
        op_q <= op_stg_q;
      end
      start_q     <= start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign start     = start_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rx_interface.sv
// Self-checking bench for rx_interface: directed frames plus randomized traffic,
// compared every cycle against a frame-level reference model.
module tb_rx_interface;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic       tx_busy = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rd, start, frame_err;
  logic [7:0] a, b;
  logic [5:0] op;

  always #5 clk = ~clk;

  rx_interface #(
    .DBIT(8),
    .OPW(6),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .tx_busy  (tx_busy),
    .rd       (rd),
    .a        (a),
    .b        (b),
    .op       (op),
    .start    (start),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  // FIFO contents offered to the DUT; gate forces rx_empty for stall cycles.
  logic [7:0] fifo[$];
  bit         gate = 1'b1;
  bit         rand_mode = 1'b0;

  // Reference model: bytes of the frame being assembled and the frame awaiting issue.
  logic [7:0] frame[$];
  bit         pending;
  int         age;
  int         idle;
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  bit         m_start, m_ferr;
  int         n_start_model = 0, n_ferr_model = 0;
  int         seen_start = 0, seen_ferr = 0;

  logic [7:0] legal_ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_accepted(input logic [7:0] v);
`ifdef OPCODE_CHECK_EN
    foreach (legal_ops[i]) if (legal_ops[i] == v) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    frame.delete();
    pending = 1'b0;
    age     = 0;
    idle    = 0;
    m_a     = '0;
    m_b     = '0;
    m_op    = '0;
    m_start = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // Advance the model by one clock edge given the pre-edge inputs.
  task automatic model_step(input bit popped, input logic [7:0] dat, input bit busy);
    m_start = 1'b0;
    m_ferr  = 1'b0;
    if (pending) begin
      age++;
      if (age == 1) begin
        m_a  = frame[0];
        m_b  = frame[1];
        m_op = frame[2][5:0];
      end else if (!busy) begin
        m_start = 1'b1;
        pending = 1'b0;
        frame.delete();
      end
    end else if (popped) begin
      frame.push_back(dat);
      idle = 0;
      if (frame.size() == 3) begin
        if (op_accepted(frame[2])) begin
          pending = 1'b1;
          age     = 0;
        end else begin
          m_ferr = 1'b1;
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      idle++;
      if (idle == T) begin
        m_ferr = 1'b1;
        frame.delete();
        idle = 0;
      end
    end
    if (m_start) n_start_model++;
    if (m_ferr) n_ferr_model++;
  endtask

  task automatic cycle();
    bit         exp_rd, busy;
    logic [7:0] dat;
    if (rand_mode) begin
      gate    = ($urandom % 4) == 0;
      tx_busy = ($urandom % 3) == 0;
    end
    rx_empty = gate || (fifo.size() == 0);
    r_data   = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
    @(negedge clk);
    exp_rd = !pending && !rx_empty;
    check("rd", rd, exp_rd);
    dat  = r_data;
    busy = tx_busy;
    @(posedge clk);
    #1;
    if (reset) begin
      model_step(exp_rd, dat, busy);
      if (exp_rd) void'(fifo.pop_front());
    end
    check("a", a, m_a);
    check("b", b, m_b);
    check("op", op, m_op);
    check("start", start, m_start);
    check("frame_err", frame_err, m_ferr);
    if (start) seen_start++;
    if (frame_err) seen_ferr++;
  endtask

  task automatic push3(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    fifo.push_back(x);
    fifo.push_back(y);
    fifo.push_back(z);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 400;
    while (budget > 0 && (fifo.size() != 0 || pending || frame.size() != 0)) begin
      cycle();
      budget--;
    end
    check(tag, int'(fifo.size() != 0 || pending || frame.size() != 0), 0);
  endtask

  initial begin
    int s0, f0, budget;
    model_reset();
    reset   = 1'b0;
    gate    = 1'b1;
    tx_busy = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    gate  = 1'b0;

    // Back-to-back frame, no backpressure.
    s0 = seen_start;
    push3(8'h05, 8'hFD, 8'h20);
    drain("drain_basic");
    check("basic_a", a, 8'h05);
    check("basic_b", b, 8'hFD);
    check("basic_op", op, 6'h20);
    check("basic_starts", seen_start - s0, 1);

    // Start withheld while tx_busy.
    s0 = seen_start;
    tx_busy = 1'b1;
    push3(8'h05, 8'hFD, 8'h20);
    budget = 20;
    while (!pending && budget > 0) begin
      cycle();
      budget--;
    end
    repeat (10) cycle();
    check("busy_no_start", seen_start - s0, 0);
    tx_busy = 1'b0;
    drain("drain_busy");
    check("busy_starts", seen_start - s0, 1);
    check("busy_op", op, 6'h20);

    // Timeout drops a partial frame; the next frame is clean.
    f0 = seen_ferr;
    s0 = seen_start;
    fifo.push_back(8'h10);
    fifo.push_back(8'h03);
    drain("drain_timeout");
    check("timeout_ferr", seen_ferr - f0, 1);
    check("timeout_no_start", seen_start - s0, 0);
    push3(8'h07, 8'h01, 8'h22);
    drain("drain_after_to");
    check("after_to_a", a, 8'h07);
    check("after_to_b", b, 8'h01);
    check("after_to_op", op, 6'h22);

    // Byte arriving on the terminal cycle wins over the timeout.
    f0 = seen_ferr;
    s0 = seen_start;
    fifo.push_back(8'h10);
    fifo.push_back(8'h03);
    budget = 60;
    while (!(frame.size() == 2 && idle == T - 1) && budget > 0) begin
      cycle();
      budget--;
    end
    check("edge_reached", idle, T - 1);
    fifo.push_back(8'h20);
    drain("drain_edge");
    check("edge_no_ferr", seen_ferr - f0, 0);
    check("edge_start", seen_start - s0, 1);
    check("edge_a", a, 8'h10);
    check("edge_b", b, 8'h03);

    // Asynchronous reset in the middle of a frame.
    fifo.push_back(8'hAA);
    budget = 10;
    while (frame.size() != 1 && budget > 0) begin
      cycle();
      budget--;
    end
    #2;
    reset = 1'b0;
    gate  = 1'b1;
    model_reset();
    #1;
    check("rst_a", a, 8'h00);
    check("rst_b", b, 8'h00);
    check("rst_op", op, 6'h00);
    repeat (2) cycle();
    reset = 1'b1;
    gate  = 1'b0;
    push3(8'h33, 8'h44, 8'h20);
    drain("drain_rst");
    check("rst_next_a", a, 8'h33);
    check("rst_next_b", b, 8'h44);

    // Opcode outside the legal set.
    push3(8'h09, 8'h08, 8'h22);
    drain("drain_pre_bad");
    f0 = seen_ferr;
    s0 = seen_start;
    push3(8'h01, 8'h02, 8'h3F);
    drain("drain_bad_op");
`ifdef OPCODE_CHECK_EN
    check("bad_ferr", seen_ferr - f0, 1);
    check("bad_no_start", seen_start - s0, 0);
    check("bad_keep_a", a, 8'h09);
    check("bad_keep_op", op, 6'h22);
`else
    check("any_op_start", seen_start - s0, 1);
    check("any_op_op", op, 6'h3F);
    check("any_op_a", a, 8'h01);
`endif

    // Randomized traffic with stalls and backpressure.
    rand_mode = 1'b1;
    repeat (15) begin
      int nfr;
      nfr = 1 + int'($urandom % 3);
      repeat (nfr) begin
        logic [7:0] opb;
        opb = (($urandom % 4) == 0) ? 8'($urandom) : legal_ops[$urandom % 8];
        push3(8'($urandom), 8'($urandom), opb);
      end
      drain("drain_rand");
    end
    rand_mode = 1'b0;
    gate      = 1'b0;
    tx_busy   = 1'b0;
    repeat (3) cycle();
    check("total_starts", seen_start, n_start_model);
    check("total_ferrs", seen_ferr, n_ferr_model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
